// File: rtl/ks_accumulator_pkg.sv
// rtl/ks_accumulator_pkg.sv - shared state enum and default widths for ks_accumulator
package ks_accumulator_pkg;

  localparam int KS_N     = 32;
  localparam int KS_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } ks_state_e;

endpackage

// File: rtl/n_bit_pg_carry_ripple.sv
// rtl/n_bit_pg_carry_ripple.sv - Kogge-Stone parallel-prefix adder with carry-in and carry-out
module n_bit_pg_carry_ripple #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  localparam int LV = $clog2(W);

  logic [W-1:0] hp;
  logic [W-1:0] gk;
  logic [W-1:0] pk;
  logic [W-1:0] gn;
  logic [W-1:0] pn;
  logic [W:0]   c;

  assign hp = a_i ^ b_i;

  // Carry-in is folded into bit 0's generate so the prefix tree yields every carry directly.
  always_comb begin
    gk    = a_i & b_i;
    gk[0] = gk[0] | (hp[0] & cin_i);
    pk    = hp;
    gn    = gk;
    pn    = pk;
    for (int l = 0; l < LV; l++) begin
      gn = gk;
      pn = pk;
      for (int i = 0; i < W; i++) begin
        if (i >= (1 << l)) begin
          gn[i] = gk[i] | (pk[i] & gk[i - (1 << l)]);
          pn[i] = pk[i] & pk[i - (1 << l)];
        end
      end
      gk = gn;
      pk = pn;
    end
  end

  assign c      = {gk, cin_i};
  assign sum_o  = hp ^ c[W-1:0];
  assign cout_o = c[W];

endmodule

// File: rtl/ks_accumulator.sv
// rtl/ks_accumulator.sv - framed add/subtract accumulator with carry, sticky overflow and beat count
module ks_accumulator
  import ks_accumulator_pkg::*;
#(
  parameter int N     = KS_N,
  parameter int CNT_W = KS_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  ks_state_e        state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [N-1:0]     b_op;
  logic [N-1:0]     sum;
  logic             cout;
  logic             ovf_beat;

  // Subtraction is A + ~B + 1, so the adder's carry-in doubles as the subtract select.
  assign b_op = in_sub ? ~in_data : in_data;

  n_bit_pg_carry_ripple #(
    .W (N)
  ) u_adder (
    .a_i    (acc_q),
    .b_i    (b_op),
    .cin_i  (in_sub),
    .sum_o  (sum),
    .cout_o (cout)
  );

  assign ovf_beat = (acc_q[N-1] == b_op[N-1]) && (sum[N-1] != acc_q[N-1]);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    count_d   = count_q;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACC: begin
        if (in_valid) begin
          acc_d   = sum;
          carry_d = cout;
          ovf_d   = ovf_q | ovf_beat;
          count_d = (&count_q) ? count_q : count_q + 1'b1;
          state_d = in_last ? ST_DONE : ST_ACC;
        end
      end
      ST_DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          count_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign out_sum   = acc_q;
  assign out_carry = carry_q;
  assign out_ovf   = ovf_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_ks_accumulator.sv
// tb/tb_ks_accumulator.sv - scoreboard bench for ks_accumulator
module tb_ks_accumulator;

  localparam int N     = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_sub;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_sum;
  logic             out_carry;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  typedef struct {
    logic [N-1:0]     sum;
    logic             carry;
    logic             ovf;
    logic [CNT_W-1:0] count;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ks_accumulator #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [N-1:0] s, input logic c, input logic o, input logic [CNT_W-1:0] n);
    exp_t e;
    e.sum = s; e.carry = c; e.ovf = o; e.count = n;
    sb_q.push_back(e);
  endtask

  task automatic send(input logic [N-1:0] d, input logic sub, input logic last);
    int n;
    in_data  = d;
    in_sub   = sub;
    in_last  = last;
    in_valid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 200) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready stayed %0b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every output handshake is compared against the oldest expected frame.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", {63'd0, out_valid}, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sum",   out_sum,   mon_e.sum);
        check("carry", out_carry, mon_e.carry);
        check("ovf",   out_ovf,   mon_e.ovf);
        check("count", out_count, mon_e.count);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sub    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_sum",       out_sum,   0);
    check("rst_count",     out_count, 0);
    check("rst_ovf",       out_ovf,   0);
    check("rst_carry",     out_carry, 0);
    reset = 1'b0;

    push_exp(32'd15, 1'b0, 1'b0, 8'd3);
    send(32'd5, 0, 0);
    send(32'd7, 0, 0);
    send(32'd3, 0, 1);
    check("latency_valid", out_valid, 1);

    push_exp(32'h0000_0000, 1'b1, 1'b0, 8'd2);
    send(32'hFFFF_FFFF, 0, 0);
    send(32'h0000_0001, 0, 1);

    push_exp(32'h8000_0000, 1'b0, 1'b1, 8'd2);
    send(32'h7FFF_FFFF, 0, 0);
    send(32'h0000_0001, 0, 1);
    push_exp(32'h0000_0001, 1'b0, 1'b0, 8'd1);
    send(32'h0000_0001, 0, 1);

    push_exp(32'h8000_0001, 1'b0, 1'b1, 8'd3);
    send(32'h7FFF_FFFF, 0, 0);
    send(32'h0000_0001, 0, 0);
    send(32'h0000_0001, 0, 1);

    push_exp(32'd7, 1'b1, 1'b0, 8'd2);
    send(32'd10, 0, 0);
    send(32'd3, 1, 1);
    push_exp(32'hFFFF_FFF9, 1'b0, 1'b0, 8'd2);
    send(32'd3, 0, 0);
    send(32'd10, 1, 1);

    push_exp(32'd260, 1'b0, 1'b0, 8'd255);
    for (int i = 0; i < 259; i++) send(32'd1, 0, 0);
    send(32'd1, 0, 1);

    push_exp(32'd3, 1'b0, 1'b0, 8'd2);
    send(32'd1, 0, 0);
    out_ready = 1'b0;
    send(32'd2, 0, 1);
    in_data  = 32'd9;
    in_sub   = 1'b0;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready",  in_ready,  0);
      check("bp_sum",       out_sum,   32'd3);
      check("bp_count",     out_count, 8'd2);
    end
    @(posedge clk);
    #1;
    push_exp(32'd9, 1'b0, 1'b0, 8'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hs_out_valid", out_valid, 0);
    check("hs_in_ready",  in_ready,  1);
    @(posedge clk);
    #1;
    check("pend_accepted", out_valid, 1);
    in_valid = 1'b0;

    send(32'd10, 0, 0);
    send(32'd20, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready",  in_ready,  1);
    check("mid_rst_sum",       out_sum,   0);
    check("mid_rst_count",     out_count, 0);
    check("mid_rst_ovf",       out_ovf,   0);
    check("mid_rst_carry",     out_carry, 0);
    reset = 1'b0;
    push_exp(32'd4, 1'b0, 1'b0, 8'd1);
    send(32'd4, 0, 1);

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ks_accumulator.md
KS_ACCUMULATOR -- requirements
Module: ks_accumulator

Interface
REQ-001 Parameter N, default 32: datapath width in bits.
REQ-002 Parameter CNT_W, default 8: beat-counter width in bits.
REQ-003 clk  in  1  the single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  input beat offered.
REQ-006 in_ready  out  1  block accepts a beat this cycle.
REQ-007 in_data  in  N  operand.
REQ-008 in_sub  in  1  1 = subtract in_data, 0 = add in_data.
REQ-009 in_last  in  1  final beat of the frame.
REQ-010 out_valid  out  1  frame result available.
REQ-011 out_ready  in  1  consumer takes the result.
REQ-012 out_sum  out  N  accumulated sum, modulo 2^N.
REQ-013 out_carry  out  1  carry-out of the final beat's addition.
REQ-014 out_ovf  out  1  sticky two's-complement overflow over the frame.
REQ-015 out_count  out  CNT_W  number of beats in the frame, saturating.

Function
REQ-016 The block SHALL have the states IDLE (acc = 0, no beats), ACC (frame open) and DONE (result held).
REQ-017 A beat SHALL be accepted only on a cycle with in_valid & in_ready; in_ready SHALL be 1 in IDLE and ACC and 0 in DONE.
REQ-018 Each accepted beat SHALL update acc to the adder output, with A = acc, B = in_sub ? ~in_data : in_data, and Cin = in_sub.
REQ-019 The accumulator, carry flag, overflow flag and count SHALL update on the edge that accepts the beat.
REQ-020 The overflow flag SHALL be set when A[N-1] == B[N-1] and sum[N-1] != A[N-1].
REQ-021 Once set, the overflow flag SHALL stay set until the frame ends.
REQ-022 The carry flag SHALL be overwritten with the adder Cout on each beat.
REQ-023 The count SHALL increment per accepted beat and saturate at 2^CNT_W-1.
REQ-024 Transitions SHALL be: IDLE to ACC on an accepted non-last beat; IDLE or ACC to DONE on an accepted last beat; ACC to ACC on other accepted beats; DONE to IDLE on out_valid & out_ready.
REQ-025 A single-beat frame SHALL go directly from IDLE to DONE.
REQ-026 out_valid SHALL be 1 exactly while in DONE, i.e. from the cycle after the last beat is accepted (latency 1).
REQ-027 out_sum, out_carry, out_ovf and out_count SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-028 On the DONE to IDLE transition, acc, flags and count SHALL clear to 0.
REQ-029 A new beat SHALL NOT be accepted in the cycle of the output handshake; the earliest acceptance is the next cycle.
REQ-030 out_ready SHALL be ignored while out_valid = 0.
REQ-031 A beat offered while in_ready = 0 SHALL NOT be consumed and SHALL NOT change state.
REQ-032 Arithmetic SHALL wrap modulo 2^N with no saturation of the sum.
REQ-033 out_sum, out_carry, out_ovf and out_count SHALL be driven directly from the registers.

Reset
REQ-034 On reset = 1 at a clock edge, state SHALL go to IDLE and acc, carry, ovf and count SHALL go to 0.
REQ-035 During and after that reset, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-036 Reset mid-frame or in DONE SHALL discard the partial or held result; the next frame SHALL start from acc = 0.
REQ-037 Reset SHALL take priority over any simultaneous handshake.

Structure
REQ-038 A shared package SHALL hold the state enum (IDLE, ACC, DONE) and the default N and CNT_W constants.
REQ-039 The single sub-module SHALL be the team's 32-bit Kogge-Stone adder (n_bit_pg_carry_ripple), instantiated once.
REQ-040 The adder SHALL be the only adder in the block; the block's own logic SHALL consist only of the registers, the FSM and the operand inversion.

Verification
REQ-041 Scenario add frame: beats +5, +7, +3(last) -> one cycle after the last beat, out_valid=1, out_sum=15, out_carry=0, out_ovf=0, out_count=3.
REQ-042 Scenario unsigned carry: +0xFFFFFFFF, +0x00000001(last) -> out_sum=0, out_carry=1, out_ovf=0, out_count=2.
REQ-043 Scenario signed overflow: +0x7FFFFFFF, +0x00000001(last) -> out_sum=0x80000000, out_ovf=1; the next frame +1(last) -> out_ovf=0.
REQ-044 Scenario subtract:
- +10, sub 3(last) -> out_sum=7, out_carry=1.
- +3, sub 10(last) -> out_sum=0xFFFFFFF9, out_carry=0.
REQ-045 Scenario backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> outputs stable, in_ready=0, no beat consumed; out_ready=1 -> IDLE, and the pending beat is accepted the next cycle.
REQ-046 Scenario reset: assert reset after 2 accepted beats -> all outputs 0, in_ready=1; then +4(last) -> out_sum=4, out_count=1.
